// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the core (master) and the data-memory
// responder (slave): a valid/ready request channel and a valid/ready
// response channel.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for an RV32I load/store port.
// One request outstanding at a time; the memory is read and written on the
// accept edge and the response appears LATENCY edges later, held until the
// core takes it.
// Optional build macro: DMEM_ERR_EN enables access-fault detection
// (illegal funct3, misalignment, out-of-range). Without it, accesses are
// force-aligned, addresses wrap and rsp_err is always 0.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           reset,
  dmem_responder_if.slave io_bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;
  logic        r_err;

  logic [AW-1:0] w_idx;
  logic [1:0]    w_size;
  logic [1:0]    w_off;
  logic          w_uns;
  logic          w_f3_ok;
  logic          w_err;
  logic          w_wr_ok;
  logic [3:0]    w_be;
  logic [31:0]    w_wlanes;
  logic [31:0]    w_rword;
  logic          w_unused_addr;

  // Sign/zero-extend the addressed byte or halfword of a memory word.
  function automatic logic [31:0] f_load_ext(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic        uns,
                                             input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0:    res = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    res = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] f_wlanes(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] lanes;
    case (size)
      2'd0:    lanes = {4{wd[7:0]}};
      2'd1:    lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  assign w_idx         = io_bus.req_addr[AW+1:2];
  assign w_uns         = io_bus.req_funct3[2];
  assign w_unused_addr = ^io_bus.req_addr[31:AW+2];
  assign w_rword       = r_mem[w_idx];
  assign w_be          = f_be(w_size, w_off);
  assign w_wlanes      = f_wlanes(w_size, io_bus.req_wdata);

  // Decode access size, effective lane offset, fault and write permission.
  always_comb begin
    w_f3_ok = io_bus.req_we ? (io_bus.req_funct3 <= 3'd2)
                            : (io_bus.req_funct3 != 3'd3 &&
                               io_bus.req_funct3 != 3'd6 &&
                               io_bus.req_funct3 != 3'd7);
`ifdef DMEM_ERR_EN
    w_size  = io_bus.req_funct3[1:0];
    w_off   = io_bus.req_addr[1:0];
    w_err   = !w_f3_ok
            || (w_size == 2'd1 && io_bus.req_addr[0])
            || (w_size == 2'd2 && io_bus.req_addr[1:0] != 2'b00)
            || (io_bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
    w_wr_ok = io_bus.req_we && !w_err;
`else
    // Illegal load encodings read the full word; illegal stores write nothing.
    w_size  = w_f3_ok ? io_bus.req_funct3[1:0] : 2'd2;
    w_off   = 2'b00;
    if (w_size == 2'd0)
      w_off = io_bus.req_addr[1:0];
    else if (w_size == 2'd1)
      w_off = {io_bus.req_addr[1], 1'b0};
    w_err   = 1'b0;
    w_wr_ok = io_bus.req_we && w_f3_ok;
`endif
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0)
          w_state_nxt = S_RESP;
        else
          w_cnt_nxt = r_cnt - 4'd1;
      end
      S_RESP: begin
        if (io_bus.rsp_ready)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the response on the accept edge; it stays put until the next accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_err   <= w_err;
      r_rdata <= (io_bus.req_we || w_err) ? 32'd0
                                          : f_load_ext(w_rword, w_size, w_uns, w_off);
    end
  end

  // Byte-lane store into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && w_accept && w_wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  assign io_bus.req_ready = (r_state == S_IDLE);
  assign io_bus.rsp_valid = (r_state == S_RESP);
  assign io_bus.rsp_rdata = r_rdata;
  assign io_bus.rsp_err   = r_err;

endmodule
